// File: rtl/sobel_pkg.sv
// sobel_pkg: pixel, window-row and FSM state types shared by the line buffer, window builder and Sobel core.
package sobel_pkg;
    localparam int PIX_W = 24;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [2:0] win_row_t;
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;
endpackage

// File: rtl/window_row_shift.sv
// window_row_shift: 3-deep pixel shift register, oldest pixel in the top slice, newest in the bottom slice.
module window_row_shift #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [3*DATA_WIDTH-1:0] dout
);
    logic [3*DATA_WIDTH-1:0] base;
    // A clear in the same cycle as an enable keeps the incoming pixel as the first column.
    assign base = clr ? '0 : dout;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout <= '0;
        else if (clr || en) dout <= en ? {base[2*DATA_WIDTH-1:0], din} : base;
endmodule

// File: rtl/sobel_window_builder.sv
// sobel_window_builder: builds 3x3 windows from line-buffer row taps and flags windows fully inside the frame.
module sobel_window_builder
    import sobel_pkg::*;
#(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int DATA_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sof,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       row0,
    input  logic [DATA_WIDTH-1:0]       row1,
    input  logic [DATA_WIDTH-1:0]       row2,
    output logic [3*DATA_WIDTH-1:0]     win_top,
    output logic [3*DATA_WIDTH-1:0]     win_mid,
    output logic [3*DATA_WIDTH-1:0]     win_bot,
    output logic                        win_valid,
    output logic [$clog2(HEIGHT)-1:0]   ctr_row,
    output logic [$clog2(WIDTH)-1:0]    ctr_col,
    output logic                        frame_done,
    output logic                        busy
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nx;
    logic [RW-1:0] row_cnt, r, row_nx;
    logic [CW-1:0] col_cnt, c, col_nx;
    logic accept, eol, last;
    // sof restarts the position so a coincident sample is pixel (0,0).
    always_comb begin
        accept   = in_valid && (sof || state == S_ACTIVE);
        r        = sof ? '0 : row_cnt;
        c        = sof ? '0 : col_cnt;
        eol      = c == CW'(WIDTH - 1);
        last     = accept && eol && r == RW'(HEIGHT - 1);
        col_nx   = !accept ? c : eol ? '0 : c + 1'b1;
        row_nx   = (!accept || !eol) ? r : last ? '0 : r + 1'b1;
        state_nx = sof ? S_ACTIVE : state == S_ACTIVE ? (last ? S_DONE : S_ACTIVE) : S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            win_valid <= 1'b0;
            ctr_row   <= '0;
            ctr_col   <= '0;
        end else begin
            state     <= state_nx;
            row_cnt   <= row_nx;
            col_cnt   <= col_nx;
            win_valid <= accept && r >= RW'(2) && c >= CW'(2);
            if (accept) begin
                ctr_row <= r - 1'b1;
                ctr_col <= c - 1'b1;
            end
        end
    assign frame_done = state == S_DONE;
    assign busy       = state == S_ACTIVE;
    window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_top (
        .clk(clk), .rst_n(rst_n), .clr(sof), .en(accept), .din(row0), .dout(win_top));
    window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_mid (
        .clk(clk), .rst_n(rst_n), .clr(sof), .en(accept), .din(row1), .dout(win_mid));
    window_row_shift #(.DATA_WIDTH(DATA_WIDTH)) u_bot (
        .clk(clk), .rst_n(rst_n), .clr(sof), .en(accept), .din(row2), .dout(win_bot));
endmodule

// File: tb/tb_sobel_window_builder.sv
// tb_sobel_window_builder: directed table-driven check of the window builder on a 4x4 frame of P(r,c)=r*16+c.
module tb_sobel_window_builder;
    logic clk = 0, rst_n = 0, sof = 0, in_valid = 0;
    logic [23:0] row0 = 0, row1 = 0, row2 = 0;
    logic [71:0] win_top, win_mid, win_bot;
    logic win_valid, frame_done, busy;
    logic [1:0] ctr_row, ctr_col;
    int n_chk = 0, n_fail = 0, nv;

    sobel_window_builder #(.WIDTH(4), .HEIGHT(4), .DATA_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid),
        .row0(row0), .row1(row1), .row2(row2),
        .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
        .win_valid(win_valid), .ctr_row(ctr_row), .ctr_col(ctr_col),
        .frame_done(frame_done), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {int r; int c; bit vld; bit done;} vec_t;
    vec_t tbl[16];

    function automatic logic [23:0] p(int r, int c);
        return (r < 0) ? 24'd0 : 24'(r * 16 + c);
    endfunction

    function automatic logic [71:0] wrow(int r, int c);
        return {p(r, c - 2), p(r, c - 1), p(r, c)};
    endfunction

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(bit s, bit v, int r, int c);
        sof = s; in_valid = v;
        row2 = v ? p(r, c) : 24'd0;
        row1 = v ? p(r - 1, c) : 24'd0;
        row0 = v ? p(r - 2, c) : 24'd0;
        @(posedge clk); #1;
        sof = 0; in_valid = 0;
    endtask

    task automatic run_frame(int gap, int upto);
        logic [71:0] hold;
        nv = 0;
        for (int i = 0; i < upto; i++) begin
            step(i == 0, 1, tbl[i].r, tbl[i].c);
            check("win_valid", 72'(win_valid), 72'(tbl[i].vld));
            check("frame_done", 72'(frame_done), 72'(tbl[i].done && upto == 16));
            check("busy", 72'(busy), 72'(!(tbl[i].done && upto == 16)));
            if (win_valid) nv++;
            if (tbl[i].vld) begin
                check("ctr_row", 72'(ctr_row), 72'(tbl[i].r - 1));
                check("ctr_col", 72'(ctr_col), 72'(tbl[i].c - 1));
                check("win_top", win_top, wrow(tbl[i].r - 2, tbl[i].c));
                check("win_mid", win_mid, wrow(tbl[i].r - 1, tbl[i].c));
                check("win_bot", win_bot, wrow(tbl[i].r, tbl[i].c));
            end
            if (i == 10) begin
                check("first_top", win_top, 72'h000000_000001_000002);
                check("first_mid", win_mid, 72'h000010_000011_000012);
                check("first_bot", win_bot, 72'h000020_000021_000022);
                check("first_ctr", 72'({ctr_row, ctr_col}), 72'h5);
            end
            if (i == 14) begin
                check("wrap_ctr", 72'({ctr_row, ctr_col}), 72'h9);
                check("wrap_bot", win_bot, 72'h000030_000031_000032);
            end
            if (i == 15) check("last_bot", win_bot, 72'h000031_000032_000033);
            hold = win_bot;
            for (int g = 0; g < gap; g++) begin
                step(0, 0, 0, 0);
                check("gap_valid", 72'(win_valid), 72'd0);
                check("gap_hold", win_bot, hold);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{i / 4, i % 4, 1'b0, 1'b0};
        tbl[10].vld = 1; tbl[11].vld = 1; tbl[14].vld = 1; tbl[15].vld = 1;
        tbl[15].done = 1;

        #12;
        check("rst_valid", 72'(win_valid), 72'd0);
        check("rst_bot", win_bot, 72'd0);
        check("rst_busy_done", 72'({busy, frame_done}), 72'd0);
        @(negedge clk); rst_n = 1;
        step(0, 1, 0, 0);
        check("idle_ignore", 72'({busy, win_bot[23:0]}), 72'd0);

        run_frame(0, 16);
        check("pulses_b2b", 72'(nv), 72'd4);
        step(0, 0, 0, 0);
        check("post_done", 72'({frame_done, busy, win_valid}), 72'd0);

        run_frame(3, 16);
        check("pulses_gap", 72'(nv), 72'd4);
        step(0, 0, 0, 0);

        run_frame(0, 9);
        run_frame(0, 16);
        check("pulses_restart", 72'(nv), 72'd4);
        step(0, 0, 0, 0);

        run_frame(0, 6);
        check("pre_rst_busy", 72'(busy), 72'd1);
        #3 rst_n = 0; #1;
        check("arst_bot", win_bot, 72'd0);
        check("arst_top", win_top, 72'd0);
        check("arst_flags", 72'({busy, frame_done, win_valid, ctr_row, ctr_col}), 72'd0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2, 2);
            check("post_rst_ignore", 72'({busy, win_valid, win_bot[23:0]}), 72'd0);
        end
        run_frame(0, 16);
        check("pulses_after_rst", 72'(nv), 72'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
